// File: rtl/mod_counter_pkg.sv
// Shared types and elaboration helpers for the modulo-N up/down counter.
package mod_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  // The upper width bound keeps the 2**width arithmetic inside a longint.
  function automatic bit legal_modulus(input int width, input int modulus);
    return (width >= 1) && (width <= 31) && (modulus >= 2) &&
           (longint'(modulus) <= (longint'(1) << width));
  endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control/status bundle between a counter user (master) and the counter (slave).
interface mod_updown_counter_if #(
  parameter int WIDTH = 3
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             en;
  logic             up;
  logic             oneshot;
  logic [WIDTH-1:0] count;
  logic             active;
  logic             tc;
  logic             err;

  modport master (
    output load, din, en, up, oneshot,
    input  count, active, tc, err
  );

  modport slave (
    input  load, din, en, up, oneshot,
    output count, active, tc, err
  );
endinterface

// File: rtl/mod_step.sv
// Combinational next-value and terminal detection for one modulo-N count step.
module mod_step #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             up,
  input  logic             oneshot,
  output logic [WIDTH-1:0] nxt,
  output logic             at_terminal
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  always_comb begin
    at_terminal = up ? (cur == LAST) : (cur == '0);
    if (at_terminal) begin
      // One-shot parks on the terminal value; cyclic mode wraps to the far end.
      nxt = oneshot ? cur : (up ? '0 : LAST);
    end else begin
      nxt = up ? (cur + ONE) : (cur - ONE);
    end
  end
endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with load, enable, cyclic/one-shot modes and IDLE/RUN/HALT FSM.
module mod_updown_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input logic                 clk,
  input logic                 reset_n,
  mod_updown_counter_if.slave bus
);
  generate
    if (!legal_modulus(WIDTH, MODULUS)) begin : g_bad_params
      $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             active_q, tc_q, tc_d, err_q, err_d;
  logic [WIDTH-1:0] step_nxt;
  logic             step_term;
  logic             din_legal;

  mod_step #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_step (
    .cur         (count_q),
    .up          (bus.up),
    .oneshot     (bus.oneshot),
    .nxt         (step_nxt),
    .at_terminal (step_term)
  );

  assign din_legal = ({1'b0, bus.din} < MOD_EXT);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    err_d   = 1'b0;
    if (bus.load) begin
      if (din_legal) begin
        state_d = RUN;
        count_d = bus.din;
      end else begin
        state_d = IDLE;
        count_d = '0;
        err_d   = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: count_d = '0;
        RUN: begin
          if (bus.en) begin
            count_d = step_nxt;
            tc_d    = step_term;
            if (step_term && bus.oneshot) state_d = HALT;
          end
        end
        HALT: count_d = count_q;
        default: begin
          // Unused encoding: fall back to a clean idle state.
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      active_q <= 1'b0;
      tc_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      active_q <= (state_d == RUN);
      tc_q     <= tc_d;
      err_q    <= err_d;
    end
  end

  assign bus.count  = count_q;
  assign bus.active = active_q;
  assign bus.tc     = tc_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: an 8-modulus 3-bit and a 10-modulus 4-bit instance.
module tb_mod_updown_counter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mod_updown_counter_if #(.WIDTH(3)) b8 ();
  mod_updown_counter_if #(.WIDTH(4)) b10 ();

  mod_updown_counter #(.WIDTH(3), .MODULUS(8)) u8 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b8.slave)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u10 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b10.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input int c, input int a, input int t, input int e);
    chk({tag, ".count"},  int'(b8.count),  c);
    chk({tag, ".active"}, int'(b8.active), a);
    chk({tag, ".tc"},     int'(b8.tc),     t);
    chk({tag, ".err"},    int'(b8.err),    e);
  endtask

  task automatic chk10(input string tag, input int c, input int a, input int t, input int e);
    chk({tag, ".count"},  int'(b10.count),  c);
    chk({tag, ".active"}, int'(b10.active), a);
    chk({tag, ".tc"},     int'(b10.tc),     t);
    chk({tag, ".err"},    int'(b10.err),    e);
  endtask

  initial begin
    b8.load = 0;  b8.din = '0;  b8.en = 0;  b8.up = 0;  b8.oneshot = 0;
    b10.load = 0; b10.din = '0; b10.en = 0; b10.up = 0; b10.oneshot = 0;

    // Reset state
    tick(); tick();
    chk8("rst8", 0, 0, 0, 0);
    chk10("rst10", 0, 0, 0, 0);
    reset_n = 1'b1;

    // 1: async reset mid-count at count=5
    b8.load = 1; b8.din = 3; tick();
    b8.load = 0; b8.en = 1; b8.up = 1;
    chk8("t1_load3", 3, 1, 0, 0);
    tick(); tick();
    chk8("t1_cnt5", 5, 1, 0, 0);
    #2 reset_n = 1'b0;
    #1 chk8("t1_async", 0, 0, 0, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    tick();
    chk8("t1_idle_en_ignored", 0, 0, 0, 0);

    // 2: down count 2,1,0,7 with wrap pulse on 7
    b8.en = 0; b8.up = 0; b8.load = 1; b8.din = 2; tick();
    b8.load = 0; b8.en = 1;
    chk8("t2_load2", 2, 1, 0, 0);
    tick(); chk8("t2_c1", 1, 1, 0, 0);
    tick(); chk8("t2_c0", 0, 1, 0, 0);
    tick(); chk8("t2_wrap7", 7, 1, 1, 0);
    tick(); chk8("t2_c6", 6, 1, 0, 0);

    // up wrap 7 -> 0
    b8.load = 1; b8.din = 7; b8.up = 1; tick();
    b8.load = 0;
    chk8("t2_load7", 7, 1, 0, 0);
    tick(); chk8("t2_upwrap0", 0, 1, 1, 0);
    b8.en = 0;

    // 5: load beats en at count=3
    b8.load = 1; b8.din = 3; tick();
    chk8("t5_load3", 3, 1, 0, 0);
    b8.din = 6; b8.en = 1; b8.up = 1; tick();
    b8.load = 0; b8.en = 0;
    chk8("t5_load_wins", 6, 1, 0, 0);

    // 6: direction toggling from 4
    b8.load = 1; b8.din = 4; tick();
    b8.load = 0; b8.en = 1; b8.up = 1;
    chk8("t6_load4", 4, 1, 0, 0);
    tick(); chk("t6_a5", int'(b8.count), 5); b8.up = 0;
    tick(); chk("t6_b4", int'(b8.count), 4); b8.up = 1;
    tick(); chk("t6_c5", int'(b8.count), 5); b8.up = 0;
    tick(); chk("t6_d4", int'(b8.count), 4); b8.en = 0;
    tick(); chk8("t6_hold1", 4, 1, 0, 0);
    tick(); chk8("t6_hold2", 4, 1, 0, 0);

    // 3: one-shot up 8 -> 9 -> HALT
    b10.load = 1; b10.din = 8; b10.up = 1; b10.oneshot = 1; tick();
    b10.load = 0; b10.en = 1;
    chk10("t3_load8", 8, 1, 0, 0);
    tick(); chk10("t3_c9", 9, 1, 0, 0);
    tick(); chk10("t3_stop", 9, 0, 1, 0);
    tick(); chk10("t3_halt1", 9, 0, 0, 0);
    tick(); chk10("t3_halt2", 9, 0, 0, 0);

    // 4: illegal load din=12 -> IDLE, err pulse, en ignored
    b10.load = 1; b10.din = 12; tick();
    b10.load = 0;
    chk10("t4_err", 0, 0, 0, 1);
    tick(); chk10("t4_idle1", 0, 0, 0, 0);
    tick(); chk10("t4_idle2", 0, 0, 0, 0);

    // Modulus boundary: 10 illegal, 9 legal
    b10.load = 1; b10.din = 10; tick();
    chk10("bnd_din10", 0, 0, 0, 1);
    b10.din = 9; tick();
    b10.load = 0; b10.en = 0;
    chk10("bnd_din9", 9, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule
